// File: rtl/reg_file_sb_pkg.sv
// Shared constants for the architectural register file and its write scoreboard.
package reg_file_sb_pkg;

   localparam int XLEN_DEF   = 64;
   localparam int PEND_W_DEF = 2;
   localparam int REG_ADDR_W = 5;
   localparam int REG_NUM    = 32;
   localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/reg_file_sb_sb_counter.sv
// One register's pending-write counter: saturating up/down with flush clear.
module sb_counter #(
   parameter int PEND_W = 2
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              inc,
   input  logic              dec,
   input  logic              clr,
   output logic [PEND_W-1:0] cnt,
   output logic              zero,
   output logic              max
);

   logic [PEND_W-1:0] cnt_r;

   assign zero = (cnt_r == {PEND_W{1'b0}});
   assign max  = (cnt_r == {PEND_W{1'b1}});
   assign cnt  = cnt_r;

   // Counter update; simultaneous inc and dec cancel, saturation holds silently here.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt_r <= {PEND_W{1'b0}};
      end else if (clr) begin
         cnt_r <= {PEND_W{1'b0}};
      end else if (inc && !dec && !max) begin
         cnt_r <= cnt_r + PEND_W'(1);
      end else if (dec && !inc && !zero) begin
         cnt_r <= cnt_r - PEND_W'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

endmodule

// File: rtl/reg_file_sb.sv
// 32 x XLEN integer register file (x0 = 0) with write-back bypass on both read
// ports and a per-register pending-write scoreboard for RAW stalls.
module reg_file_sb
   import reg_file_sb_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int PEND_W = PEND_W_DEF
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            wb_rd_wen_i,
   input  logic [4:0]      wb_rd_addr_i,
   input  logic [XLEN-1:0] wb_rd_wdata_i,
   input  logic            rs1_ren_i,
   input  logic [4:0]      rs1_addr_i,
   input  logic            rs2_ren_i,
   input  logic [4:0]      rs2_addr_i,
   output logic [XLEN-1:0] rs1_data_o,
   output logic [XLEN-1:0] rs2_data_o,
   output logic            rs1_busy_o,
   output logic            rs2_busy_o,
   input  logic            sb_set_i,
   input  logic [4:0]      sb_set_addr_i,
   input  logic            flush_i,
   output logic            sb_ovf_o
);

   logic [XLEN-1:0]    regs_r [REG_NUM];
   logic [PEND_W-1:0]  cnt_s  [REG_NUM];
   logic [REG_NUM-1:0] inc_s;
   logic [REG_NUM-1:0] dec_s;
   logic [REG_NUM-1:0] zero_s;
   logic [REG_NUM-1:0] max_s;
   logic [REG_NUM-1:0] last_s;
   logic               ovf_r;

   // Decode the scoreboard set and write-back addresses into per-register strobes.
   always_comb begin
      inc_s = {REG_NUM{1'b0}};
      dec_s = {REG_NUM{1'b0}};
      for (int i = 1; i < REG_NUM; i++) begin
         inc_s[i] = sb_set_i & (sb_set_addr_i == REG_ADDR_W'(i));
         dec_s[i] = wb_rd_wen_i & (wb_rd_addr_i == REG_ADDR_W'(i));
      end
   end

   // Storage write; entry 0 is never written so it stays at its reset value of zero.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < REG_NUM; i++) begin
            regs_r[i] <= {XLEN{1'b0}};
         end
      end else if (wb_rd_wen_i && (wb_rd_addr_i != ZERO_REG)) begin
         regs_r[wb_rd_addr_i] <= wb_rd_wdata_i;
      end else begin
         regs_r[wb_rd_addr_i] <= regs_r[wb_rd_addr_i];
      end
   end

   assign cnt_s[0]  = {PEND_W{1'b0}};
   assign zero_s[0] = 1'b1;
   assign max_s[0]  = 1'b0;
   assign last_s[0] = 1'b0;

   for (genvar g = 1; g < REG_NUM; g++) begin : g_cnt
      sb_counter #(.PEND_W(PEND_W)) u_cnt (
         .clock   (clock),
         .reset_n (reset_n),
         .inc     (inc_s[g]),
         .dec     (dec_s[g]),
         .clr     (flush_i),
         .cnt     (cnt_s[g]),
         .zero    (zero_s[g]),
         .max     (max_s[g])
      );
      // The final outstanding write landing now is covered by the bypass.
      assign last_s[g] = dec_s[g] & (cnt_s[g] == PEND_W'(1));
   end

   // Sticky overflow: a set that the counter had to drop; flush overrides the set.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ovf_r <= 1'b0;
      end else if (!flush_i && (|(inc_s & ~dec_s & max_s))) begin
         ovf_r <= 1'b1;
      end else begin
         ovf_r <= ovf_r;
      end
   end

   assign sb_ovf_o = ovf_r;

   function automatic logic [XLEN-1:0] read_port(input logic            ren,
                                                 input logic [4:0]      addr,
                                                 input logic [XLEN-1:0] stored);
      logic [XLEN-1:0] data;
      if (!ren || (addr == ZERO_REG)) begin
         data = {XLEN{1'b0}};
      end else if (wb_rd_wen_i && (wb_rd_addr_i == addr)) begin
         data = wb_rd_wdata_i;
      end else begin
         data = stored;
      end
      return data;
   endfunction

   // Combinational read ports with write-through bypass and stall flags.
   always_comb begin
      rs1_data_o = read_port(rs1_ren_i, rs1_addr_i, regs_r[rs1_addr_i]);
      rs2_data_o = read_port(rs2_ren_i, rs2_addr_i, regs_r[rs2_addr_i]);
      rs1_busy_o = rs1_ren_i & (rs1_addr_i != ZERO_REG) &
                   ~zero_s[rs1_addr_i] & ~last_s[rs1_addr_i];
      rs2_busy_o = rs2_ren_i & (rs2_addr_i != ZERO_REG) &
                   ~zero_s[rs2_addr_i] & ~last_s[rs2_addr_i];
   end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Architectural integer register file: 32 x 64 bit, with x0 hardwired to zero.
- It is the receiving end of the write-back interface. It consumes the rd write-enable, address and data driven by the WB stage.
- Provides two decode-stage read ports with same-cycle WB bypass.
- Contains a per-register pending-write scoreboard. Decode uses it to stall on RAW hazards (e.g. load-use) until the producing write-back lands.

Parameters:
- XLEN, 64, register data width.
- PEND_W, 2, width of each register's pending-write counter (max in-flight writers per register = 2^PEND_W-1).

Ports:
- clock  input  1  system clock, all state updates on rising edge
- reset_n  input  1  asynchronous active-low reset
- wb_rd_wen_i  input  1  write-back write enable
- wb_rd_addr_i  input  5  write-back destination register
- wb_rd_wdata_i  input  XLEN  write-back data
- rs1_ren_i  input  1  read enable, port 1
- rs1_addr_i  input  5  read address, port 1
- rs2_ren_i  input  1  read enable, port 2
- rs2_addr_i  input  5  read address, port 2
- rs1_data_o  output  XLEN  read data, port 1 (combinational)
- rs2_data_o  output  XLEN  read data, port 2 (combinational)
- rs1_busy_o  output  1  port-1 source has a pending write, stall
- rs2_busy_o  output  1  port-2 source has a pending write, stall
- sb_set_i  input  1  issuing instruction will write sb_set_addr_i
- sb_set_addr_i  input  5  destination of issuing instruction
- flush_i  input  1  pipeline flush, clear all pending counters
- sb_ovf_o  output  1  sticky: set attempted on a saturated counter

Behaviour:
- Reset (async, reset_n=0): all 31 registers, all counters and sb_ovf_o go to 0. While reset is asserted, read data outputs reflect zeroed storage and busy outputs are 0.
- Write: on a rising edge with wb_rd_wen_i=1 and wb_rd_addr_i!=0, reg[wb_rd_addr_i] <= wb_rd_wdata_i. Writes to x0 are dropped.
- Read data, per port, combinational, in priority order:
  - ren=0 or addr=0 -> 0.
  - wb_rd_wen_i=1 and wb_rd_addr_i==addr -> wb_rd_wdata_i (write-through bypass).
  - Otherwise -> reg[addr].
- Scoreboard: one PEND_W-bit counter per register; cnt[0] is constant 0.
  - inc = sb_set_i & (sb_set_addr_i!=0).
  - dec = wb_rd_wen_i & (wb_rd_addr_i!=0).
  - Same register hit by both inc and dec in one cycle -> counter unchanged.
  - inc only -> +1, unless the counter is at max: it holds and sb_ovf_o <= 1.
  - dec only -> -1, unless the counter is 0: it holds, with no flag (WB of an unscoreboarded write is legal).
  - flush_i=1 -> all counters <= 0 next edge, overriding inc/dec. The data write still occurs. sb_ovf_o is not cleared by flush; only reset clears it.
- Busy, per port: busy = ren & (addr!=0) & (cnt[addr]!=0) & ~(dec hits addr & cnt[addr]==1).
  - The last pending write, landing this cycle, is bypassed, so there is no stall.
  - A set in the current cycle does not affect busy until the next cycle.
- Latency:
  - Read: 0 cycles.
  - Write visible via storage: next cycle.
  - Write visible via bypass: same cycle.
- Both read ports may address the same register, and may match the WB address simultaneously; they behave independently.

Decomposition:
- Shared package/defines: XLEN, REG_ADDR_W=5, REG_NUM=32, ZERO_REG=5'd0.
- Natural sub-module: sb_counter. It is one PEND_W saturating up/down counter with inc, dec and clr inputs, and zero and max outputs. It is instantiated 31 times via generate. Storage and read muxes stay in the top module.

Test Plan:
- Reset then read: reset_n low for 2 cycles, then read x5 and x31 -> both data 0, busy 0, sb_ovf_o 0.
- Write/read and x0:
  - Write x3=64'hDEAD_BEEF_0000_0001, read x3 next cycle -> same value.
  - Write x0=64'hFFFF, read x0 -> 0.
- Bypass: x7=1 stored; same cycle WB writes x7=64'h55 while rs1 and rs2 both read x7 -> both outputs 64'h55.
- Load-use stall:
  - sb_set x9 at cycle 0 -> rs1 reading x9 shows busy=1 from cycle 1.
  - WB writes x9=64'h42 at cycle 3 -> busy=0 and data 64'h42 that same cycle.
  - Counter is 0 afterward.
- Double pending and overflow (PEND_W=2):
  - Set x4 three times -> cnt=3; fourth set -> cnt stays 3, sb_ovf_o=1.
  - Three WB writes to x4 -> busy clears on the third write.
- Flush and simultaneous events:
  - cnt[6]=2, then same cycle sb_set x6 and WB x6 -> cnt stays 2.
  - Then flush_i with WB x6=64'h9 -> cnt 0, x6=64'h9, sb_ovf_o unchanged.
  - Mid-operation reset_n pulse -> all counters and registers 0 immediately.
